// File: rtl/mem_bus_if_pkg.sv
// Shared definitions for the memory-side bus interface: FSM state encoding
// and the default datapath widths used by the bus mux and register file.
package mem_bus_if_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 9;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      WR   = 3'd2,
      DONE = 3'd3,
      ERR  = 3'd4
   } state_t;

endpackage

// File: rtl/mem_bus_if_timeout_ctr.sv
// Wait-cycle counter for an outstanding memory request. Held at zero while
// cleared; counts each enabled cycle. expired flags the last cycle in which
// the request may still be acknowledged, so a request lasts TIMEOUT cycles.
module mem_timeout_ctr #(
   parameter int TIMEOUT = 15
) (
   input  logic clock,
   input  logic clear_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   logic [CW-1:0] count;

   // Count wait cycles; restart from zero whenever no request is pending.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + CW'(1);
      end
   end

   assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_if.sv
// Memory-side bus interface: MAR/MDR capture from BusMuxOut and a single
// outstanding read/write handshake to word memory with timeout abort.
module mem_bus_if
   import mem_bus_if_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int TIMEOUT = 15
) (
   input  logic              clock,
   input  logic              clear_n,
   input  logic [DATA_W-1:0] bus_in,
   input  logic              mar_in,
   input  logic              mdr_in,
   input  logic              read,
   input  logic              write,
   output logic [DATA_W-1:0] mdr_out,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rd_req,
   output logic              mem_wr_req,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              done,
   output logic              err
);

   state_t            state;
   logic [ADDR_W-1:0] mar;
   logic [DATA_W-1:0] mdr;
   logic              ctr_clr;
   logic              ctr_en;
   logic              expired;

   // Counter runs only while a request is on the bus and unanswered.
   assign ctr_clr = !((state == RD) || (state == WR));
   assign ctr_en  = !ctr_clr && !mem_ack;

   mem_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clock   (clock),
      .clear_n (clear_n),
      .clr     (ctr_clr),
      .en      (ctr_en),
      .expired (expired)
   );

   // Register outputs straight from MAR/MDR; no input-to-output paths.
   assign mdr_out   = mdr;
   assign mem_wdata = mdr;
   assign mem_addr  = mar;

   // Transaction FSM with registered handshake and status outputs.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state      <= IDLE;
         mar        <= '0;
         mdr        <= '0;
         mem_rd_req <= 1'b0;
         mem_wr_req <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (mar_in) mar <= bus_in[ADDR_W-1:0];
               if (mdr_in) mdr <= bus_in;
               if (read && write) begin
                  state <= ERR;
                  err   <= 1'b1;
                  busy  <= 1'b1;
               end else if (read) begin
                  state      <= RD;
                  mem_rd_req <= 1'b1;
                  busy       <= 1'b1;
               end else if (write) begin
                  state      <= WR;
                  mem_wr_req <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            RD: begin
               if (mem_ack) begin
                  mdr        <= mem_rdata;
                  state      <= DONE;
                  mem_rd_req <= 1'b0;
                  done       <= 1'b1;
               end else if (expired) begin
                  state      <= ERR;
                  mem_rd_req <= 1'b0;
                  err        <= 1'b1;
               end
            end
            WR: begin
               if (mem_ack) begin
                  state      <= DONE;
                  mem_wr_req <= 1'b0;
                  done       <= 1'b1;
               end else if (expired) begin
                  state      <= ERR;
                  mem_wr_req <= 1'b0;
                  err        <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            ERR: begin
               state <= IDLE;
               err   <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               mem_rd_req <= 1'b0;
               mem_wr_req <= 1'b0;
               done       <= 1'b0;
               err        <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_if.sv
// Directed bench for mem_bus_if: reset, read with waits, write, timeout,
// illegal command, ignored inputs, ack on the last allowed cycle.
module tb_mem_bus_if;

   logic        clock;
   logic        clear_n;
   logic [31:0] bus_in;
   logic        mar_in;
   logic        mdr_in;
   logic        read;
   logic        write;
   logic [31:0] mdr_out;
   logic [8:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_rd_req;
   logic        mem_wr_req;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        busy;
   logic        done;
   logic        err;

   int checks = 0;
   int passed = 0;
   int n;

   mem_bus_if #(
      .DATA_W  (32),
      .ADDR_W  (9),
      .TIMEOUT (15)
   ) dut (
      .clock      (clock),
      .clear_n    (clear_n),
      .bus_in     (bus_in),
      .mar_in     (mar_in),
      .mdr_in     (mdr_in),
      .read       (read),
      .write      (write),
      .mdr_out    (mdr_out),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rd_req (mem_rd_req),
      .mem_wr_req (mem_wr_req),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   initial begin
      clear_n   = 1'b0;
      bus_in    = '0;
      mar_in    = 1'b0;
      mdr_in    = 1'b0;
      read      = 1'b0;
      write     = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      #1;
      check("rst_rd_req", 32'(mem_rd_req), 0);
      check("rst_wr_req", 32'(mem_wr_req), 0);
      check("rst_busy",   32'(busy), 0);
      check("rst_mdr",    mdr_out, 0);
      check("rst_addr",   32'(mem_addr), 0);
      tick();
      tick();
      clear_n = 1'b1;
      tick();

      // Load MAR, then read with three wait cycles
      bus_in = 32'h0000_0105; mar_in = 1'b1;
      tick();
      mar_in = 1'b0;
      check("mar_load", 32'(mem_addr), 32'h105);
      read = 1'b1;
      tick();
      read = 1'b0;
      check("rd_req_on", 32'(mem_rd_req), 1);
      check("rd_busy", 32'(busy), 1);
      bus_in = 32'h0000_01FF; mar_in = 1'b1;   // ignored while busy
      tick();
      mar_in = 1'b0;
      tick();
      tick();
      check("rd_addr_hold", 32'(mem_addr), 32'h105);
      check("rd_req_wait", 32'(mem_rd_req), 1);
      check("rd_no_done_yet", 32'(done), 0);
      mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      tick();
      mem_ack = 1'b0; mem_rdata = '0;
      check("rd_done", 32'(done), 1);
      check("rd_mdr", mdr_out, 32'hDEAD_BEEF);
      check("rd_req_off", 32'(mem_rd_req), 0);
      check("rd_busy_done", 32'(busy), 1);
      tick();
      check("rd_done_once", 32'(done), 0);
      check("rd_idle", 32'(busy), 0);

      // Stray ack in IDLE
      mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
      tick();
      mem_ack = 1'b0; mem_rdata = '0;
      check("stray_done", 32'(done), 0);
      check("stray_mdr", mdr_out, 32'hDEAD_BEEF);
      check("stray_busy", 32'(busy), 0);

      // MDR load together with write, zero-wait ack
      bus_in = 32'h1234_5678; mdr_in = 1'b1; write = 1'b1;
      tick();
      mdr_in = 1'b0; write = 1'b0; bus_in = '0;
      check("wr_req_on", 32'(mem_wr_req), 1);
      check("wr_wdata", mem_wdata, 32'h1234_5678);
      mem_ack = 1'b1; mem_rdata = 32'h5555_0000;
      tick();
      mem_ack = 1'b0; mem_rdata = '0;
      check("wr_req_off", 32'(mem_wr_req), 0);
      check("wr_done", 32'(done), 1);
      check("wr_mdr", mdr_out, 32'h1234_5678);
      tick();
      check("wr_done_once", 32'(done), 0);
      check("wr_idle", 32'(busy), 0);

      // Read with no ack: timeout after 15 request cycles
      bus_in = 32'hAAAA_5555; mdr_in = 1'b1;
      tick();
      mdr_in = 1'b0;
      read = 1'b1;
      tick();
      read = 1'b0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (!mem_rd_req) break;
         n++;
         tick();
      end
      check("to_req_cycles", n, 15);
      check("to_err", 32'(err), 1);
      check("to_done", 32'(done), 0);
      check("to_mdr", mdr_out, 32'hAAAA_5555);
      tick();
      check("to_err_once", 32'(err), 0);
      check("to_idle", 32'(busy), 0);

      // Ack on the final allowed cycle is a success
      read = 1'b1;
      tick();
      read = 1'b0;
      for (int i = 0; i < 14; i++) tick();
      check("late_req", 32'(mem_rd_req), 1);
      mem_ack = 1'b1; mem_rdata = 32'h0BAD_CAFE;
      tick();
      mem_ack = 1'b0; mem_rdata = '0;
      check("late_done", 32'(done), 1);
      check("late_err", 32'(err), 0);
      check("late_mdr", mdr_out, 32'h0BAD_CAFE);
      tick();

      // read and write together
      read = 1'b1; write = 1'b1;
      tick();
      read = 1'b0; write = 1'b0;
      check("rw_rd_req", 32'(mem_rd_req), 0);
      check("rw_wr_req", 32'(mem_wr_req), 0);
      check("rw_err", 32'(err), 1);
      check("rw_busy", 32'(busy), 1);
      tick();
      check("rw_err_off", 32'(err), 0);
      check("rw_idle", 32'(busy), 0);

      // Asynchronous reset in the middle of a read
      read = 1'b1;
      tick();
      read = 1'b0;
      check("mid_rd_req", 32'(mem_rd_req), 1);
      #2;
      clear_n = 1'b0;
      #1;
      check("async_rd_req", 32'(mem_rd_req), 0);
      check("async_busy", 32'(busy), 0);
      check("async_mdr", mdr_out, 0);
      check("async_addr", 32'(mem_addr), 0);
      tick();
      clear_n = 1'b1;
      tick();

      // Normal operation after reset
      bus_in = 32'hCAFE_F00D; mdr_in = 1'b1; write = 1'b1;
      tick();
      mdr_in = 1'b0; write = 1'b0;
      check("post_wr_req", 32'(mem_wr_req), 1);
      check("post_wdata", mem_wdata, 32'hCAFE_F00D);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      check("post_done", 32'(done), 1);
      tick();
      check("post_idle", 32'(busy), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
